// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter sharing one register-bank load line.
// grant_idx feeds the dmux8way sel; a dead cycle always separates grants.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    last, last_nxt;
    logic [IDX_W-1:0]    idx_nxt;
    logic [N-1:0]        grant_nxt;
    logic                valid_nxt;
    logic                timeout_nxt;
    logic [HOLD_W-1:0]   cnt, cnt_nxt;

    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    cand;
    logic                found;
    logic                rel;

    // Rotating-priority scan: first set request after last, wrapping back to last itself.
    always_comb begin
        pick  = last;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IDX_W'(32'(last) + i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        idx_nxt     = grant_idx;
        grant_nxt   = grant;
        valid_nxt   = grant_valid;
        timeout_nxt = 1'b0;
        cnt_nxt     = cnt;
        rel         = 1'b0;

        case (state)
            IDLE: begin
                grant_nxt = '0;
                valid_nxt = 1'b0;
                cnt_nxt   = '0;
                if (found) begin
                    idx_nxt   = pick;
                    grant_nxt = N'(1) << pick;
                    valid_nxt = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Done/drop release takes precedence over the hold timeout.
                if (!req[grant_idx] || done) begin
                    rel = 1'b1;
                end else if ((MAX_HOLD != 0) && (cnt == HOLD_LAST)) begin
                    rel         = 1'b1;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + HOLD_W'(1);
                end
                if (rel) begin
                    last_nxt  = grant_idx;
                    valid_nxt = 1'b0;
                    grant_nxt = '0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                valid_nxt = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= IDX_W'(N - 1);
            grant_idx   <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            last        <= last_nxt;
            grant_idx   <= idx_nxt;
            grant       <= grant_nxt;
            grant_valid <= valid_nxt;
            timeout     <= timeout_nxt;
            cnt         <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus a randomized run
// checked against a cycle-level model of the arbitration rules.
module tb_rr_arbiter8;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int fails  = 0;

    // Model: who holds the line, how long they've held it, and who went last.
    bit m_valid = 1'b0;
    bit m_to    = 1'b0;
    int m_idx   = 0;
    int m_last  = 7;
    int m_age   = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(MH), .HOLD_W(8)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
    );

    function automatic int winner(int after, logic [7:0] rq);
        for (int k = 1; k <= 8; k++) begin
            if (rq[(after + k) % 8]) return (after + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        m_to = 1'b0;
        if (reset) begin
            m_valid = 1'b0; m_idx = 0; m_last = 7; m_age = 0;
        end else if (!m_valid) begin
            w = winner(m_last, req);
            if (w >= 0) begin
                m_idx = w; m_valid = 1'b1; m_age = 1;
            end
        end else if (!req[m_idx] || done) begin
            m_last = m_idx; m_valid = 1'b0;
        end else if (m_age == MH) begin
            m_last = m_idx; m_valid = 1'b0; m_to = 1'b1;
        end else begin
            m_age++;
        end
    endtask

    function automatic logic [12:0] expv();
        logic [7:0] g;
        g = '0;
        if (m_valid) g[m_idx] = 1'b1;
        return {g, 3'(m_idx), m_valid, m_to};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; done = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 8'hFF; done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cyc();
            checks++;
            if ({grant, grant_valid, timeout} !== 10'h000) begin
                fails++;
                $display("FAIL reset[%0d]: grant=%h valid=%b timeout=%b, expected 00/0/0", c, grant, grant_valid, timeout);
            end
        end
        reset = 1'b0;
        cyc();
        checks++;
        if (grant !== 8'h01 || grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
            fails++;
            $display("FAIL first_grant: grant=%h idx=%0d valid=%b, expected 01/0/1", grant, grant_idx, grant_valid);
        end
    endtask

    task automatic test_rotation();
        int seq[$];
        do_reset();
        req = 8'hFF;
        for (int c = 0; c < 17; c++) begin
            done = m_valid;
            cyc();
            checks++;
            if ({grant, grant_idx, grant_valid, timeout} !== expv()) begin
                fails++;
                $display("FAIL rotation[%0d]: got %h expected %h", c, {grant, grant_idx, grant_valid, timeout}, expv());
            end
            if (grant_valid === 1'b1) seq.push_back(int'(grant_idx));
        end
        done = 1'b0;
        checks++;
        if (seq.size() != 9) begin
            fails++;
            $display("FAIL rotation_count: got %0d grants, expected 9", seq.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (seq[i] != i % 8) begin
                    fails++;
                    $display("FAIL rotation_order[%0d]: got idx %0d expected %0d", i, seq[i], i % 8);
                end
            end
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        req = 8'h20;
        cyc();
        checks++;
        if (grant !== 8'h20) begin fails++; $display("FAIL wrap_first: grant=%h expected 20", grant); end
        done = 1'b1;
        cyc();
        checks++;
        if (grant_valid !== 1'b0) begin fails++; $display("FAIL wrap_release: valid=%b expected 0", grant_valid); end
        done = 1'b0; req = 8'h21;
        cyc();
        checks++;
        if (grant !== 8'h01 || grant_idx !== 3'd0) begin fails++; $display("FAIL wrap_skip: grant=%h idx=%0d expected 01/0", grant, grant_idx); end
        done = 1'b1;
        cyc();
        done = 1'b0; req = 8'h20;
        cyc();
        checks++;
        if (grant !== 8'h20 || grant_idx !== 3'd5) begin fails++; $display("FAIL wrap_back: grant=%h idx=%0d expected 20/5", grant, grant_idx); end
    endtask

    task automatic test_timeout();
        int run = 0, first_run = -1, to_cyc = -1;
        do_reset();
        req = 8'h08; done = 1'b0;
        for (int c = 0; c < 11; c++) begin
            cyc();
            checks++;
            if ({grant, grant_idx, grant_valid, timeout} !== expv()) begin
                fails++;
                $display("FAIL timeout_model[%0d]: got %h expected %h", c, {grant, grant_idx, grant_valid, timeout}, expv());
            end
            if (to_cyc >= 0 && c == to_cyc + 1) begin
                checks++;
                if (grant !== 8'h08 || grant_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL timeout_regrant: grant=%h valid=%b expected 08/1", grant, grant_valid);
                end
            end
            if (timeout === 1'b1 && to_cyc < 0) begin
                to_cyc = c; first_run = run;
            end
            if (grant_valid === 1'b1) run++;
        end
        checks++;
        if (first_run != MH) begin
            fails++;
            $display("FAIL timeout_len: held %0d cycles before timeout, expected %0d", first_run, MH);
        end
    endtask

    task automatic test_collision();
        do_reset();
        req = 8'h08; done = 1'b0;
        for (int c = 0; c < MH; c++) cyc();
        done = 1'b1;
        cyc();
        checks++;
        if (timeout !== 1'b0 || grant_valid !== 1'b0) begin
            fails++;
            $display("FAIL collision: timeout=%b valid=%b expected 0/0", timeout, grant_valid);
        end
        done = 1'b0;
        do_reset();
        req = 8'h04;
        cyc();
        req = 8'h05;
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++;
            if (grant !== 8'h04 || grant_idx !== 3'd2) begin
                fails++;
                $display("FAIL preempt[%0d]: grant=%h idx=%0d expected 04/2", c, grant, grant_idx);
            end
        end
        done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        checks++;
        if (grant !== 8'h01) begin fails++; $display("FAIL after_preempt: grant=%h expected 01", grant); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h30;
        cyc();
        done = 1'b1;
        cyc();
        done = 1'b0; req = 8'h10;
        cyc();
        checks++;
        if (grant !== 8'h10) begin fails++; $display("FAIL mid_setup: grant=%h expected 10", grant); end
        reset = 1'b1; done = 1'b1; req = 8'h30;
        cyc();
        checks++;
        if ({grant, grant_valid, timeout} !== 10'h000) begin
            fails++;
            $display("FAIL mid_reset: grant=%h valid=%b timeout=%b expected 00/0/0", grant, grant_valid, timeout);
        end
        reset = 1'b0; done = 1'b0;
        cyc();
        checks++;
        if (grant !== 8'h10 || grant_idx !== 3'd4) begin
            fails++;
            $display("FAIL mid_pointer: grant=%h idx=%0d expected 10/4", grant, grant_idx);
        end
    endtask

    task automatic test_random();
        do_reset();
        req = 8'h00;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            done  = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 63) == 0);
            cyc();
            checks++;
            if ({grant, grant_idx, grant_valid, timeout} !== expv()) begin
                fails++;
                $display("FAIL random[%0d]: got %h expected %h", c, {grant, grant_idx, grant_valid, timeout}, expv());
            end
        end
        reset = 1'b0; done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 8'h00; done = 1'b0;
        test_reset();
        test_rotation();
        test_wrap_skip();
        test_timeout();
        test_collision();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
